// File: rtl/alu_riscv_mdu.sv
// alu_riscv_mdu: multi-cycle RV32I ALU/compare unit with RV32M multiply/divide.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 synchronous abort of any in-flight operation
//   req_valid_i/req_ready_o request handshake (ready only in IDLE and out of reset)
//   mdu_en_i                1: M-extension op from mdu_op_i, 0: base op from alu_op_i
//   alu_op_i, mdu_op_i      opcodes (alu_opcodes_pkg encodings / RV32M funct3)
//   a_i, b_i                operands, captured at accept
//   rsp_valid_o/rsp_ready_i response handshake
//   result_o, flag_o        registered result and compare flag
//
// MUL* and DIV*/REM* run iteratively (one bit per cycle) on operand magnitudes,
// unless MUL_FAST=1 for the multiplies or the divide hits a special case.

package alu_opcodes_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_EQ   = 5'd10,
        ALU_NE   = 5'd11,
        ALU_LTS  = 5'd12,
        ALU_GES  = 5'd13,
        ALU_LTU  = 5'd14,
        ALU_GEU  = 5'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

endpackage

module alu_riscv_mdu
    import alu_opcodes_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter bit          MUL_FAST = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             mdu_en_i,
    input  logic [4:0]       alu_op_i,
    input  logic [2:0]       mdu_op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             flag_o
);

    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;      // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;      // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] opb_q, opb_d;    // multiplicand / divisor magnitude
    logic [2:0]       mop_q, mop_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;

    // Base ALU
    logic [WIDTH-1:0] base_res;
    logic             base_flag;
    logic             lt_s, lt_u;
    logic [SW-1:0]    shamt;

    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;
    assign shamt = b_i[SW-1:0];

    always_comb begin
        base_res  = '0;
        base_flag = 1'b0;
        case (alu_op_i)
            ALU_ADD:  base_res = a_i + b_i;
            ALU_SUB:  base_res = a_i - b_i;
            ALU_SLL:  base_res = a_i << shamt;
            ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_XOR:  base_res = a_i ^ b_i;
            ALU_SRL:  base_res = a_i >> shamt;
            ALU_SRA:  base_res = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   base_res = a_i | b_i;
            ALU_AND:  base_res = a_i & b_i;
            ALU_EQ:   base_flag = (a_i == b_i);
            ALU_NE:   base_flag = (a_i != b_i);
            ALU_LTS:  base_flag = lt_s;
            ALU_GES:  base_flag = ~lt_s;
            ALU_LTU:  base_flag = lt_u;
            ALU_GEU:  base_flag = ~lt_u;
            default:  ;
        endcase
    end

    // MDU request decode (operands as presented at accept)
    logic             is_mul, a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, special_res;
    logic             neg_start, div_zero, div_ovf;
    logic [2*WIDTH-1:0] fa, fb, fp;
    logic [WIDTH-1:0] fast_res;

    always_comb begin
        is_mul = ~mdu_op_i[2];
        if (is_mul) begin
            a_sgn = (mdu_op_i == MDU_MULH) || (mdu_op_i == MDU_MULHSU);
            b_sgn = (mdu_op_i == MDU_MULH);
        end else begin
            a_sgn = ~mdu_op_i[0];
            b_sgn = ~mdu_op_i[0];
        end
        a_neg = a_sgn & a_i[WIDTH-1];
        b_neg = b_sgn & b_i[WIDTH-1];
        a_mag = a_neg ? (~a_i + 1'b1) : a_i;
        b_mag = b_neg ? (~b_i + 1'b1) : b_i;
        // REM takes the dividend's sign; DIV and MUL* the xor of both signs
        if (!is_mul && mdu_op_i[1]) neg_start = a_neg;
        else                        neg_start = a_neg ^ b_neg;

        div_zero = ~is_mul & (b_i == '0);
        div_ovf  = ~is_mul & ~mdu_op_i[0] & (b_i == '1)
                 & (a_i == {1'b1, {(WIDTH-1){1'b0}}});
        if (div_zero) special_res = mdu_op_i[1] ? a_i : '1;
        else          special_res = mdu_op_i[1] ? '0  : a_i;

        fa = a_sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        fb = b_sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
        fp = fa * fb;
        fast_res = (mdu_op_i == MDU_MUL) ? fp[WIDTH-1:0] : fp[2*WIDTH-1:WIDTH];
    end

    // One iteration step of shift-add multiply / restoring divide
    logic [WIDTH:0]     mul_sum, r_sh, r_diff;
    logic [2*WIDTH-1:0] prod_n, prod_f;
    logic [WIDTH-1:0]   hi_n, lo_n, div_sel, final_res;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        prod_n  = {mul_sum, lo_q[WIDTH-1:1]};
        r_sh    = {hi_q, lo_q[WIDTH-1]};
        r_diff  = r_sh - {1'b0, opb_q};
        if (!mop_q[2]) begin
            hi_n = prod_n[2*WIDTH-1:WIDTH];
            lo_n = prod_n[WIDTH-1:0];
        end else if (!r_diff[WIDTH]) begin
            hi_n = r_diff[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = r_sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
        prod_f  = neg_q ? (~prod_n + 1'b1) : prod_n;
        div_sel = mop_q[1] ? hi_n : lo_n;
        if (!mop_q[2])
            final_res = (mop_q == MDU_MUL) ? prod_f[WIDTH-1:0] : prod_f[2*WIDTH-1:WIDTH];
        else
            final_res = neg_q ? (~div_sel + 1'b1) : div_sel;
    end

    // Next-state / datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        mop_d    = mop_q;
        neg_d    = neg_q;
        result_d = result_q;
        flag_d   = flag_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (!mdu_en_i) begin
                            result_d = base_res;
                            flag_d   = base_flag;
                            state_d  = S_DONE;
                        end else begin
                            flag_d = 1'b0;
                            if (div_zero || div_ovf) begin
                                result_d = special_res;
                                state_d  = S_DONE;
                            end else if (is_mul && MUL_FAST) begin
                                result_d = fast_res;
                                state_d  = S_DONE;
                            end else begin
                                state_d = S_CALC;
                                cnt_d   = SW'(WIDTH-1);
                                hi_d    = '0;
                                lo_d    = is_mul ? b_mag : a_mag;
                                opb_d   = is_mul ? a_mag : b_mag;
                                mop_d   = mdu_op_i;
                                neg_d   = neg_start;
                            end
                        end
                    end
                end
                S_CALC: begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_d = final_res;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (rsp_ready_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            mop_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            mop_q    <= mop_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE) & ~rst_i;
    assign rsp_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;
    assign flag_o      = flag_q;

endmodule

// File: tb/tb_alu_riscv_mdu.sv
module tb_alu_riscv_mdu;
    import alu_opcodes_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        mdu_en_i = 1'b0;
    logic [4:0]  alu_op_i = '0;
    logic [2:0]  mdu_op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] result_o;
    logic        flag_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    alu_riscv_mdu #(.WIDTH(32), .MUL_FAST(1'b0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .mdu_en_i(mdu_en_i), .alu_op_i(alu_op_i), .mdu_op_i(mdu_op_i),
        .a_i(a_i), .b_i(b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .result_o(result_o), .flag_o(flag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model from the architectural definition using plain arithmetic
    task automatic ref_model(input logic en, input logic [4:0] aop, input logic [2:0] mop,
                             input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output logic flg, output int lat);
        int          sa, sb;
        logic [63:0] p;
        bit          ovf;
        sa  = a;
        sb  = b;
        res = '0;
        flg = 1'b0;
        lat = 1;
        if (!en) begin
            case (aop)
                5'd0:  res = a + b;
                5'd1:  res = a - b;
                5'd2:  res = a << b[4:0];
                5'd3:  res = (sa < sb) ? 32'd1 : 32'd0;
                5'd4:  res = (a < b) ? 32'd1 : 32'd0;
                5'd5:  res = a ^ b;
                5'd6:  res = a >> b[4:0];
                5'd7:  res = sa >>> b[4:0];
                5'd8:  res = a | b;
                5'd9:  res = a & b;
                5'd10: flg = (a == b);
                5'd11: flg = (a != b);
                5'd12: flg = (sa < sb);
                5'd13: flg = (sa >= sb);
                5'd14: flg = (a < b);
                5'd15: flg = (a >= b);
                default: ;
            endcase
        end else begin
            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
            case (mop)
                3'd0: begin p = {32'b0, a} * {32'b0, b}; res = p[31:0]; lat = 33; end
                3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; res = p[63:32]; lat = 33; end
                3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; res = p[63:32]; lat = 33; end
                3'd3: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; lat = 33; end
                3'd4: begin
                    if (b == 0)   res = 32'hFFFF_FFFF;
                    else if (ovf) res = a;
                    else begin res = sa / sb; lat = 33; end
                end
                3'd5: begin
                    if (b == 0) res = 32'hFFFF_FFFF;
                    else begin res = a / b; lat = 33; end
                end
                3'd6: begin
                    if (b == 0)   res = a;
                    else if (ovf) res = 32'd0;
                    else begin res = sa % sb; lat = 33; end
                end
                default: begin
                    if (b == 0) res = a;
                    else begin res = a % b; lat = 33; end
                end
            endcase
        end
    endtask

    // Issue one request, check latency/result/flag, optionally stall the response
    task automatic run_op(input string tag, input logic en, input logic [4:0] aop,
                          input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] eres;
        logic        eflg;
        int          elat;
        int          cnt;
        ref_model(en, aop, mop, a, b, eres, eflg, elat);
        @(negedge clk_i);
        mdu_en_i    = en;
        alu_op_i    = aop;
        mdu_op_i    = mop;
        a_i         = a;
        b_i         = b;
        req_valid_i = 1'b1;
        rsp_ready_i = (hold == 0);
        check_eq({tag, ".req_ready"}, req_ready_o, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        cnt = 1;
        while (!rsp_valid_o && cnt < 100) begin
            @(posedge clk_i);
            @(negedge clk_i);
            cnt++;
        end
        check_eq({tag, ".latency"}, cnt, elat);
        check_eq({tag, ".result"}, result_o, eres);
        check_eq({tag, ".flag"}, flag_o, eflg);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check_eq({tag, ".hold_valid"}, rsp_valid_o, 1);
            check_eq({tag, ".hold_result"}, result_o, eres);
            check_eq({tag, ".hold_ready"}, req_ready_o, 0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check_eq({tag, ".rsp_done"}, rsp_valid_o, 0);
        check_eq({tag, ".ready_again"}, req_ready_o, 1);
    endtask

    // Start an iterative op and leave it running
    task automatic start_op(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        mdu_en_i    = 1'b1;
        mdu_op_i    = mop;
        a_i         = a;
        b_i         = b;
        req_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic expect_no_rsp(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (rsp_valid_o) seen++;
        end
        check_eq(tag, seen, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        logic [2:0]  rmop;
        logic        ren;

        #12;
        check_eq("reset.req_ready", req_ready_o, 0);
        check_eq("reset.rsp_valid", rsp_valid_o, 0);
        check_eq("reset.result", result_o, 0);
        check_eq("reset.flag", flag_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_eq("post_reset.req_ready", req_ready_o, 1);

        // Directed cases
        run_op("add", 1'b0, ALU_ADD, 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("ltu", 1'b0, ALU_LTU, 3'd0, 32'd1, 32'hFFFF_FFFF, 0);
        run_op("lts", 1'b0, ALU_LTS, 3'd0, 32'd1, 32'hFFFF_FFFF, 0);
        run_op("sra", 1'b0, ALU_SRA, 3'd0, 32'h8000_0000, 32'd35, 0);
        run_op("unknown", 1'b0, 5'd20, 3'd0, 32'd9, 32'd9, 0);
        run_op("mulh", 1'b1, 5'd0, MDU_MULH, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhsu", 1'b1, 5'd0, MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhu", 1'b1, 5'd0, MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div", 1'b1, 5'd0, MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem", 1'b1, 5'd0, MDU_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu", 1'b1, 5'd0, MDU_DIVU, 32'd100, 32'd7, 0);
        run_op("remu", 1'b1, 5'd0, MDU_REMU, 32'd100, 32'd7, 0);
        run_op("div0", 1'b1, 5'd0, MDU_DIV, 32'd5, 32'd0, 0);
        run_op("rem0", 1'b1, 5'd0, MDU_REM, 32'd5, 32'd0, 0);
        run_op("divovf", 1'b1, 5'd0, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("removf", 1'b1, 5'd0, MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("mul_hold", 1'b1, 5'd0, MDU_MUL, 32'd3, 32'd5, 4);

        // Flush part-way through a DIVU
        start_op(MDU_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        check_eq("flush.rsp_valid", rsp_valid_o, 0);
        check_eq("flush.req_ready", req_ready_o, 1);
        expect_no_rsp("flush.no_rsp", 40);

        // Asynchronous reset in the middle of a MUL
        start_op(MDU_MUL, 32'd12345, 32'd678);
        repeat (5) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("midrst.req_ready", req_ready_o, 0);
        check_eq("midrst.rsp_valid", rsp_valid_o, 0);
        check_eq("midrst.result", result_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        expect_no_rsp("midrst.no_rsp", 40);
        run_op("add_after", 1'b0, ALU_ADD, 3'd0, 32'd1, 32'd1, 0);

        // Randomized sweep
        for (int n = 0; n < 60; n++) begin
            ren  = $urandom_range(0, 1);
            rop  = $urandom_range(0, 17);
            rmop = $urandom_range(0, 7);
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 20);
                3: ra = rb;
                default: ;
            endcase
            run_op("rand", ren, rop, rmop, ra, rb, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
